// File: rtl/mouv_regbank_pkg.sv
// Shared definitions for the movement-analysis AXI4-Lite register bank:
// response codes, address-map sizing helpers and the slot decode function.
package mouv_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    DEC_RW   = 2'd0,
    DEC_RO   = 2'd1,
    DEC_IRQ  = 2'd2,
    DEC_NONE = 2'd3
  } dec_t;

  // Byte-offset bits below the register index
  function automatic int calc_addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Index field wide enough for every RW/RO slot plus the interrupt slot
  function automatic int calc_idx_w(input int num_rw, input int num_ro);
    return $clog2(num_rw + num_ro + 1);
  endfunction

  // Classify a register index into its slot kind
  function automatic dec_t decode_idx(input int unsigned idx, input int unsigned num_rw,
                                      input int unsigned num_ro, input bit irq_en);
    if (idx < num_rw) return DEC_RW;
    if (idx < num_rw + num_ro) return DEC_RO;
    if (irq_en && (idx == num_rw + num_ro)) return DEC_IRQ;
    return DEC_NONE;
  endfunction

  // Write response for a decoded slot: status registers reject writes
  function automatic logic [1:0] wr_resp(input dec_t dec);
    case (dec)
      DEC_RW, DEC_IRQ: return RESP_OKAY;
      DEC_RO:          return RESP_SLVERR;
      default:         return RESP_DECERR;
    endcase
  endfunction

endpackage

// File: rtl/mouv_axil_wr_ctrl.sv
// AXI4-Lite write-side control: independent one-entry AW and W holding
// slots, commit generation and the B response channel.
module mouv_axil_wr_ctrl
  import mouv_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 4,
  parameter int IDX_W      = 4,
  parameter bit IRQ_EN     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IDX_W-1:0]        aw_idx,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,
  output logic                    commit,
  output logic [IDX_W-1:0]        commit_idx,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb
);

  logic                    rdy_en;
  logic                    aw_vld_p0;
  logic [IDX_W-1:0]        aw_idx_p0;
  logic                    w_vld_p0;
  logic [DATA_WIDTH-1:0]   w_data_p0;
  logic [DATA_WIDTH/8-1:0] w_strb_p0;
  logic                    aw_hs;
  logic                    w_hs;

  // READY is held low through reset and reflects an empty slot afterwards
  assign aw_ready = rdy_en & ~aw_vld_p0;
  assign w_ready  = rdy_en & ~w_vld_p0;
  assign aw_hs    = aw_valid & aw_ready;
  assign w_hs     = w_valid & w_ready;

  // A write retires once both halves are present and the B slot can take it
  assign commit      = aw_vld_p0 & w_vld_p0 & (~b_valid | b_ready);
  assign commit_idx  = aw_idx_p0;
  assign commit_data = w_data_p0;
  assign commit_strb = w_strb_p0;

  // Slot occupancy and B channel state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      aw_vld_p0 <= 1'b0;
      w_vld_p0  <= 1'b0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
    end else begin
      rdy_en <= 1'b1;
      if (commit) aw_vld_p0 <= 1'b0;
      else if (aw_hs) aw_vld_p0 <= 1'b1;
      if (commit) w_vld_p0 <= 1'b0;
      else if (w_hs) w_vld_p0 <= 1'b1;
      if (commit) begin
        b_valid <= 1'b1;
        b_resp  <= wr_resp(decode_idx(32'(aw_idx_p0), NUM_RW, NUM_RO, IRQ_EN));
      end else if (b_ready) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Holding-slot payload, qualified by the occupancy flags above
  always_ff @(posedge clk) begin
    if (aw_hs) aw_idx_p0 <= aw_idx;
    if (w_hs) begin
      w_data_p0 <= w_data;
      w_strb_p0 <= w_strb;
    end
  end

endmodule

// File: rtl/mouv_axil_regbank.sv
// Parametrised AXI4-Lite register bank for the movement-analysis core:
// NUM_RW byte-strobed control registers, NUM_RO status registers and
// decode/slave error responses. Optional interrupt slot enabled by
// defining MOUV_REGBANK_IRQ_EN.
module mouv_axil_regbank
  import mouv_regbank_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_RW     = 4,
  parameter int                    NUM_RO     = 4,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
`ifdef MOUV_REGBANK_IRQ_EN
  ,
  parameter int                    IRQ_W      = 4
`endif
) (
  input  logic                             ACLK,
  input  logic                             ARESETN,
  input  logic [ADDR_WIDTH-1:0]            AWADDR,
  input  logic [2:0]                       AWPROT,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [DATA_WIDTH-1:0]            WDATA,
  input  logic [DATA_WIDTH/8-1:0]          WSTRB,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [ADDR_WIDTH-1:0]            ARADDR,
  input  logic [2:0]                       ARPROT,
  input  logic                             ARVALID,
  output logic                             ARREADY,
  output logic [DATA_WIDTH-1:0]            RDATA,
  output logic [1:0]                       RRESP,
  output logic                             RVALID,
  input  logic                             RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0]     reg_out,
  output logic [NUM_RW-1:0]                reg_wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in
`ifdef MOUV_REGBANK_IRQ_EN
  ,
  input  logic [IRQ_W-1:0]                 irq_src,
  output logic                             irq
`endif
);

  localparam int ADDR_LSB = calc_addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = calc_idx_w(NUM_RW, NUM_RO);
  localparam int STRB_W   = DATA_WIDTH / 8;
`ifdef MOUV_REGBANK_IRQ_EN
  localparam bit IRQ_EN   = 1'b1;
`else
  localparam bit IRQ_EN   = 1'b0;
`endif

  logic [IDX_W-1:0]      aw_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic                  commit;
  logic [IDX_W-1:0]      c_idx;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  dec_t                  c_dec;
  dec_t                  rd_dec;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [1:0]            rd_resp;
  logic                  rd_rdy_en;
  logic                  ar_hs;
  logic [DATA_WIDTH-1:0] regs [NUM_RW];
  logic                  unused_ok;

  // Only the index field selects a register; protection and stray bits are ignored
  assign aw_idx    = AWADDR[ADDR_LSB +: IDX_W];
  assign ar_idx    = ARADDR[ADDR_LSB +: IDX_W];
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR, ARADDR};

  mouv_axil_wr_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_RW     (NUM_RW),
    .NUM_RO     (NUM_RO),
    .IDX_W      (IDX_W),
    .IRQ_EN     (IRQ_EN)
  ) u_wr_ctrl (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .aw_idx      (aw_idx),
    .aw_valid    (AWVALID),
    .aw_ready    (AWREADY),
    .w_data      (WDATA),
    .w_strb      (WSTRB),
    .w_valid     (WVALID),
    .w_ready     (WREADY),
    .b_resp      (BRESP),
    .b_valid     (BVALID),
    .b_ready     (BREADY),
    .commit      (commit),
    .commit_idx  (c_idx),
    .commit_data (c_data),
    .commit_strb (c_strb)
  );

  assign c_dec = decode_idx(32'(c_idx), NUM_RW, NUM_RO, IRQ_EN);

  // Byte-masked update of the control registers plus per-register write strobe
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_RW; k++) regs[k] <= RESET_VAL;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && (c_dec == DEC_RW)) begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (c_idx == IDX_W'(k)) begin
            reg_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (c_strb[b]) regs[k][b*8 +: 8] <= c_data[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_reg_out
    assign reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
  end

`ifdef MOUV_REGBANK_IRQ_EN
  logic [IRQ_W-1:0] src_q;
  logic [IRQ_W-1:0] pending;
  logic [IRQ_W-1:0] irq_clr;

  // Write-1-to-clear mask, honouring the byte strobes
  always_comb begin
    irq_clr = '0;
    if (commit && (c_dec == DEC_IRQ)) begin
      for (int i = 0; i < IRQ_W; i++) begin
        if (c_strb[i/8] && c_data[i]) irq_clr[i] = 1'b1;
      end
    end
  end

  // Rising-edge capture into pending; a new edge beats a same-cycle clear
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      src_q   <= '0;
      pending <= '0;
      irq     <= 1'b0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~irq_clr) | (irq_src & ~src_q);
      irq     <= |pending;
    end
  end
`endif

  // Read mux: value selected from the address presented in the handshake cycle
  always_comb begin
    rd_dec  = decode_idx(32'(ar_idx), NUM_RW, NUM_RO, IRQ_EN);
    rd_word = '0;
    rd_resp = (rd_dec == DEC_NONE) ? RESP_DECERR : RESP_OKAY;
    case (rd_dec)
      DEC_RW: begin
        for (int k = 0; k < NUM_RW; k++) begin
          if (ar_idx == IDX_W'(k)) rd_word = regs[k];
        end
      end
      DEC_RO: begin
        for (int k = 0; k < NUM_RO; k++) begin
          if (ar_idx == IDX_W'(NUM_RW + k)) rd_word = status_in[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
`ifdef MOUV_REGBANK_IRQ_EN
      DEC_IRQ: rd_word = DATA_WIDTH'(pending);
`endif
      default: rd_word = '0;
    endcase
  end

  assign ARREADY = rd_rdy_en & (~RVALID | RREADY);
  assign ar_hs   = ARVALID & ARREADY;

  // R channel: data/response registered on the AR handshake, held until RREADY
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rd_rdy_en <= 1'b0;
      RVALID    <= 1'b0;
      RDATA     <= '0;
      RRESP     <= RESP_OKAY;
    end else begin
      rd_rdy_en <= 1'b1;
      if (ar_hs) begin
        RVALID <= 1'b1;
        RDATA  <= rd_word;
        RRESP  <= rd_resp;
      end else if (RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mouv_axil_regbank.sv
// Directed self-checking bench for mouv_axil_regbank (default parameters).
// Build with MOUV_REGBANK_IRQ_EN defined to include the interrupt scenario.
`timescale 1ns/1ps
module tb_mouv_axil_regbank;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NRW = 4;
  localparam int NRO = 4;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic [AW-1:0]     AWADDR = '0;
  logic [2:0]        AWPROT = '0;
  logic              AWVALID = 1'b0;
  logic              AWREADY;
  logic [DW-1:0]     WDATA = '0;
  logic [DW/8-1:0]   WSTRB = '0;
  logic              WVALID = 1'b0;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY = 1'b0;
  logic [AW-1:0]     ARADDR = '0;
  logic [2:0]        ARPROT = '0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [DW-1:0]     RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY = 1'b0;
  logic [NRW*DW-1:0] reg_out;
  logic [NRW-1:0]    reg_wr_pulse;
  logic [NRO*DW-1:0] status_in = '0;
`ifdef MOUV_REGBANK_IRQ_EN
  logic [3:0]        irq_src = '0;
  logic              irq;
`endif

  int checks = 0;
  int errors = 0;
  int pulse_cnt [NRW] = '{default: 0};

  mouv_axil_regbank dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .AWADDR       (AWADDR),
    .AWPROT       (AWPROT),
    .AWVALID      (AWVALID),
    .AWREADY      (AWREADY),
    .WDATA        (WDATA),
    .WSTRB        (WSTRB),
    .WVALID       (WVALID),
    .WREADY       (WREADY),
    .BRESP        (BRESP),
    .BVALID       (BVALID),
    .BREADY       (BREADY),
    .ARADDR       (ARADDR),
    .ARPROT       (ARPROT),
    .ARVALID      (ARVALID),
    .ARREADY      (ARREADY),
    .RDATA        (RDATA),
    .RRESP        (RRESP),
    .RVALID       (RVALID),
    .RREADY       (RREADY),
    .reg_out      (reg_out),
    .reg_wr_pulse (reg_wr_pulse),
    .status_in    (status_in)
`ifdef MOUV_REGBANK_IRQ_EN
    ,
    .irq_src      (irq_src),
    .irq          (irq)
`endif
  );

  always #5 ACLK = ~ACLK;

  // Count strobe cycles on the falling edge, away from register updates
  always @(negedge ACLK) begin
    for (int k = 0; k < NRW; k++) if (reg_wr_pulse[k]) pulse_cnt[k] = pulse_cnt[k] + 1;
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_pulses();
    for (int k = 0; k < NRW; k++) pulse_cnt[k] = 0;
  endtask

  // Full write transaction with BREADY high; resp stays X on timeout
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hs, w_hs;
    int cyc;
    AWADDR = addr; AWVALID = 1'b1; WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = 1'b1;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'bxx;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick(); cyc++;
      if (aw_hs) begin AWVALID = 1'b0; aw_done = 1; end
      if (w_hs) begin WVALID = 1'b0; w_done = 1; end
    end
    while (!BVALID && cyc < 40) begin tick(); cyc++; end
    if (BVALID === 1'b1) begin
      resp = BRESP;
      tick();
    end else begin
      checks++; errors++;
      $display("FAIL write_timeout addr=%h: BVALID=%b required 1", addr, BVALID);
    end
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  // Full read transaction with RREADY high; outputs stay X on timeout
  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    bit hs;
    int cyc;
    ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1;
    cyc = 0; data = 'x; resp = 2'bxx; hs = 0;
    while (!hs && cyc < 20) begin
      hs = ARVALID && ARREADY;
      tick(); cyc++;
    end
    ARVALID = 1'b0;
    while (!RVALID && cyc < 40) begin tick(); cyc++; end
    if (RVALID === 1'b1) begin
      data = RDATA; resp = RRESP;
      tick();
    end else begin
      checks++; errors++;
      $display("FAIL read_timeout addr=%h: RVALID=%b required 1", addr, RVALID);
    end
  endtask

  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (2) tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID} !== 5'b0) begin
      errors++;
      $display("FAIL reset_handshake: got %b required 00000", {AWREADY, WREADY, ARREADY, BVALID, RVALID});
    end
    checks++;
    if ({BRESP, RRESP, RDATA} !== 36'h0) begin
      errors++;
      $display("FAIL reset_resp_data: got %h required 0", {BRESP, RRESP, RDATA});
    end
    checks++;
    if (reg_out !== '0 || reg_wr_pulse !== '0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%b required 0/0", reg_out, reg_wr_pulse);
    end
`ifdef MOUV_REGBANK_IRQ_EN
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
    ARESETN = 1'b1;
    tick();
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 111", {AWREADY, WREADY, ARREADY});
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0] resp;
    logic [DW-1:0] data;
    for (int i = 0; i < 4; i++) begin
      axi_write(AW'(i * 4), DW'(i + 1), 4'hF, resp);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL basic_bresp[%0d]: got %b required 00", i, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(AW'(i * 4), data, resp);
      checks++;
      if (data !== DW'(i + 1) || resp !== 2'b00) begin
        errors++;
        $display("FAIL basic_read[%0d]: got %h/%b required %h/00", i, data, resp, i + 1);
      end
    end
    checks++;
    if (reg_out !== 128'h00000004_00000003_00000002_00000001) begin
      errors++;
      $display("FAIL basic_reg_out: got %h required 4/3/2/1", reg_out);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp;
    logic [DW-1:0] data;
    axi_write(8'h04, 32'h11223344, 4'hF, resp);
    clear_pulses();
    axi_write(8'h04, 32'hAABBCCDD, 4'b0101, resp);
    repeat (2) tick();
    axi_read(8'h04, data, resp);
    checks++;
    if (data !== 32'h11BB33DD || resp !== 2'b00) begin
      errors++;
      $display("FAIL strobe_merge: got %h/%b required 11bb33dd/00", data, resp);
    end
    checks++;
    if (pulse_cnt[1] != 1 || pulse_cnt[0] != 0 || pulse_cnt[2] != 0 || pulse_cnt[3] != 0) begin
      errors++;
      $display("FAIL strobe_pulse: got %0d,%0d,%0d,%0d required 0,1,0,0",
               pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]);
    end
    clear_pulses();
    axi_write(8'h04, 32'hFFFFFFFF, 4'b0000, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL zero_strb_bresp: got %b required 00", resp); end
    repeat (2) tick();
    axi_read(8'h04, data, resp);
    checks++;
    if (data !== 32'h11BB33DD || pulse_cnt[1] != 1) begin
      errors++;
      $display("FAIL zero_strb_hold: got %h pulses %0d required 11bb33dd pulses 1", data, pulse_cnt[1]);
    end
  endtask

  task automatic test_w_first_bstall();
    BREADY = 1'b0;
    WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    tick(); tick();
    checks++;
    if (WREADY !== 1'b0 || AWREADY !== 1'b1 || BVALID !== 1'b0 || reg_out[95:64] !== 32'h3) begin
      errors++;
      $display("FAIL w_only_wait: got wr=%b awr=%b bv=%b r2=%h required 0/1/0/3",
               WREADY, AWREADY, BVALID, reg_out[95:64]);
    end
    AWADDR = 8'h08; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    tick();
    checks++;
    if (BVALID !== 1'b1 || BRESP !== 2'b00 || reg_out[95:64] !== 32'h55) begin
      errors++;
      $display("FAIL w_first_commit: got bv=%b br=%b r2=%h required 1/00/55", BVALID, BRESP, reg_out[95:64]);
    end
    AWADDR = 8'h0C; AWVALID = 1'b1; WDATA = 32'h66; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (BVALID !== 1'b1 || BRESP !== 2'b00 || AWREADY !== 1'b0 || reg_out[127:96] !== 32'h4) begin
        errors++;
        $display("FAIL bstall[%0d]: got bv=%b br=%b awr=%b r3=%h required 1/00/0/4",
                 i, BVALID, BRESP, AWREADY, reg_out[127:96]);
      end
      tick();
    end
    BREADY = 1'b1;
    tick();
    checks++;
    if (BVALID !== 1'b1 || reg_out[127:96] !== 32'h66) begin
      errors++;
      $display("FAIL bstall_release: got bv=%b r3=%h required 1/66", BVALID, reg_out[127:96]);
    end
    tick();
    checks++;
    if (BVALID !== 1'b0) begin errors++; $display("FAIL bstall_drain: got %b required 0", BVALID); end
  endtask

  task automatic test_status_errors();
    logic [1:0] resp;
    logic [DW-1:0] data;
    status_in = {32'h44440004, 32'h33330003, 32'h22220002, 32'hCAFE0001};
    tick();
    axi_read(8'h10, data, resp);
    checks++;
    if (data !== 32'hCAFE0001 || resp !== 2'b00) begin
      errors++; $display("FAIL ro_read: got %h/%b required cafe0001/00", data, resp);
    end
    axi_write(8'h10, 32'h12345678, 4'hF, resp);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL ro_write_slverr: got %b required 10", resp); end
    axi_read(8'h10, data, resp);
    checks++;
    if (data !== 32'hCAFE0001) begin errors++; $display("FAIL ro_unchanged: got %h required cafe0001", data); end
    axi_read(8'h1C, data, resp);
    checks++;
    if (data !== 32'h44440004 || resp !== 2'b00) begin
      errors++; $display("FAIL ro_last: got %h/%b required 44440004/00", data, resp);
    end
    axi_read(8'h24, data, resp);
    checks++;
    if (data !== 32'h0 || resp !== 2'b11) begin
      errors++; $display("FAIL decerr_read: got %h/%b required 0/11", data, resp);
    end
    axi_write(8'h24, 32'hFFFFFFFF, 4'hF, resp);
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL decerr_write: got %b required 11", resp); end
`ifndef MOUV_REGBANK_IRQ_EN
    axi_write(8'h20, 32'hFFFFFFFF, 4'hF, resp);
    checks++;
    if (resp !== 2'b11) begin errors++; $display("FAIL irq_slot_decerr: got %b required 11", resp); end
`endif
    checks++;
    if (reg_out !== 128'h00000066_00000055_11BB33DD_00000001) begin
      errors++; $display("FAIL err_no_change: got %h required 66/55/11bb33dd/1", reg_out);
    end
    axi_read(8'h47, data, resp);
    checks++;
    if (data !== 32'h11BB33DD || resp !== 2'b00) begin
      errors++; $display("FAIL addr_alias: got %h/%b required 11bb33dd/00", data, resp);
    end
  endtask

  task automatic test_same_edge();
    logic [1:0] resp;
    logic [DW-1:0] data;
    axi_write(8'h08, 32'h5, 4'hF, resp);
    AWADDR = 8'h08; AWVALID = 1'b1; WDATA = 32'h9; WSTRB = 4'hF; WVALID = 1'b1;
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 8'h08; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    checks++;
    if (RVALID !== 1'b1 || RDATA !== 32'h5 || reg_out[95:64] !== 32'h9 || BVALID !== 1'b1) begin
      errors++;
      $display("FAIL same_edge: got rv=%b rd=%h r2=%h bv=%b required 1/5/9/1", RVALID, RDATA, reg_out[95:64], BVALID);
    end
    tick();
    axi_read(8'h08, data, resp);
    checks++;
    if (data !== 32'h9) begin errors++; $display("FAIL same_edge_after: got %h required 9", data); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [DW-1:0] data;
    BREADY = 1'b0;
    AWADDR = 8'h00; AWVALID = 1'b1; WDATA = 32'hDEAD; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    tick();
    checks++;
    if (BVALID !== 1'b1) begin errors++; $display("FAIL mid_bvalid: got %b required 1", BVALID); end
    ARESETN = 1'b0;
    #1;
    checks++;
    if (BVALID !== 1'b0 || reg_out !== '0 || AWREADY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got bv=%b regs=%h awr=%b required 0/0/0", BVALID, reg_out, AWREADY);
    end
    tick();
    ARESETN = 1'b1;
    tick();
    axi_write(8'h00, 32'h77, 4'hF, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL post_reset_bresp: got %b required 00", resp); end
    axi_read(8'h00, data, resp);
    checks++;
    if (data !== 32'h77 || resp !== 2'b00) begin
      errors++; $display("FAIL post_reset_read: got %h/%b required 77/00", data, resp);
    end
    axi_read(8'h0C, data, resp);
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL post_reset_clear: got %h required 0", data); end
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int n, cyc;
    bit hs;
    n = 0; cyc = 0;
    AWADDR = 8'h00; WDATA = 32'hA0; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    while (n < 3 && cyc < 20) begin
      hs = AWVALID && AWREADY && WVALID && WREADY;
      tick(); cyc++;
      if (hs) begin
        acc[n] = cyc;
        n++;
        AWADDR = AW'(n * 4);
        WDATA = 32'hA0 + DW'(n);
      end
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    checks++;
    if (n != 3 || acc[2] - acc[0] != 4) begin
      errors++;
      $display("FAIL b2b_rate: got %0d accepts span %0d required 3 span 4", n, acc[2] - acc[0]);
    end
    repeat (3) tick();
    checks++;
    if (reg_out[95:0] !== 96'h000000A2_000000A1_000000A0) begin
      errors++; $display("FAIL b2b_data: got %h required a2/a1/a0", reg_out[95:0]);
    end
  endtask

`ifdef MOUV_REGBANK_IRQ_EN
  task automatic test_irq();
    logic [1:0] resp;
    logic [DW-1:0] data;
    irq_src = 4'b0100;
    tick();
    irq_src = 4'b0000;
    repeat (3) tick();
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set: got %b required 1", irq); end
    axi_read(8'h20, data, resp);
    checks++;
    if (data !== 32'h4 || resp !== 2'b00) begin
      errors++; $display("FAIL irq_pending: got %h/%b required 4/00", data, resp);
    end
    axi_write(8'h20, 32'h4, 4'hF, resp);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL irq_clr_bresp: got %b required 00", resp); end
    repeat (2) tick();
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b required 0", irq); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_rw();
    test_strobes();
    test_w_first_bstall();
    test_status_errors();
    test_same_edge();
    test_reset_mid();
    test_back_to_back();
`ifdef MOUV_REGBANK_IRQ_EN
    test_irq();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouv_axil_regbank.md
Name: mouv_axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor of the fixed 4-register slave in the movement-analysis IP.
- Provides NUM_RW software-writable control registers with byte strobes and NUM_RO read-only status registers fed from the analysis datapath.
- Returns proper error responses for illegal accesses.
- Sits between the AXI interconnect (VIP master in the BFM design) and the movement-analysis core.

Parameters:
- DATA_WIDTH, 32, AXI data width; 32 or 64 only.
- NUM_RW, 4, number of read/write control registers; 1..64.
- NUM_RO, 4, number of read-only status registers; 0..64.
- ADDR_WIDTH, 8, AXI address width; must satisfy ADDR_WIDTH >= ADDR_LSB + IDX_W (+1 slot when the IRQ feature is on).
- RESET_VAL, 0, reset value applied to every RW register.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- AWADDR  in  ADDR_WIDTH  write address
- AWPROT  in  3  ignored
- AWVALID/AWREADY  in/out  1  write-address handshake
- WDATA  in  DATA_WIDTH  write data
- WSTRB  in  DATA_WIDTH/8  byte strobes
- WVALID/WREADY  in/out  1  write-data handshake
- BRESP  out  2  write response
- BVALID/BREADY  out/in  1  write-response handshake
- ARADDR  in  ADDR_WIDTH  read address
- ARPROT  in  3  ignored
- ARVALID/ARREADY  in/out  1  read-address handshake
- RDATA  out  DATA_WIDTH  read data
- RRESP  out  2  read response
- RVALID/RREADY  out/in  1  read-data handshake
- reg_out  out  NUM_RW*DATA_WIDTH  flattened RW registers; register k at bits [k*DW +: DW]
- reg_wr_pulse  out  NUM_RW  one-cycle strobe per register written
- status_in  in  NUM_RO*DATA_WIDTH  flattened status values, synchronous to ACLK

Behaviour:
- Reset (ARESETN low, async assert, sync deassert upstream):
  - AWREADY, WREADY, ARREADY, BVALID, RVALID all 0; BRESP, RRESP, RDATA all 0.
  - reg_out = RESET_VAL; reg_wr_pulse = 0; AW/W holding slots emptied.
  - Reset mid-transaction abandons it silently.
  - READY outputs rise the first cycle after deassertion.
- Address decode:
  - ADDR_LSB = clog2(DW/8); idx = addr[ADDR_LSB +: IDX_W] with IDX_W = clog2(NUM_RW+NUM_RO+1).
  - Low byte-offset bits and bits above the index field are ignored.
- Write channel:
  - AW and W each captured independently into a one-entry holding slot; AWREADY = AW slot empty, WREADY = W slot empty. Either order, or simultaneous, accepted.
  - Commit cycle: both slots full and (BVALID=0 or BREADY=1). Slots are freed on the commit cycle, so READY can re-accept on the next edge.
  - idx < NUM_RW: bytes with WSTRB=1 updated; reg_out and reg_wr_pulse[idx] change on the edge after commit; BRESP=OKAY(00).
  - NUM_RW <= idx < NUM_RW+NUM_RO: no state change, BRESP=SLVERR(10).
  - Beyond that: no state change, BRESP=DECERR(11).
  - WSTRB=0 to an RW register: OKAY, value unchanged, reg_wr_pulse still fires.
  - BVALID rises the edge after commit and holds until BREADY.
  - Sustained throughput: one write every 2 cycles with BREADY tied high.
- Read channel:
  - ARREADY = !RVALID or RREADY (registered).
  - On AR handshake, RDATA/RRESP are registered and RVALID rises the next edge; RDATA holds stable until RREADY.
  - RW idx: register value. RO idx: status_in word sampled on the handshake cycle. Other idx: RDATA=0, RRESP=DECERR.
  - Read and write commit to the same register on the same edge: the read returns the pre-write value.
- Read and write channels operate independently and concurrently.

Optional Feature:
- Macro MOUV_REGBANK_IRQ_EN.
- Enabled:
  - Adds parameter IRQ_W (default 4), input irq_src[IRQ_W-1:0] and output irq (reset 0).
  - A rising edge on irq_src[n] sets pending[n].
  - Register slot idx = NUM_RW+NUM_RO reads pending (zero-extended) and is write-1-to-clear per strobed byte, BRESP=OKAY.
  - When set and clear coincide on the same edge, set wins.
  - irq = |pending, registered.
- Disabled: ports absent; that slot decodes as DECERR.

Decomposition:
- Package mouv_regbank_pkg:
  - Response constants RESP_OKAY / RESP_SLVERR / RESP_DECERR.
  - clog2-derived localparam helpers.
  - Typedef for the decode result (enum RW / RO / IRQ / NONE).
- One sub-module, mouv_axil_wr_ctrl: AW/W holding slots, commit and B channel; emits the commit strobe, idx, data and strobes.
- Read path and register array live in the top.

Test Plan:
- Reset, then write 0x1,0x2,0x3,0x4 to offsets 0x0..0xC; read back each -> RDATA 0x1..0x4, all BRESP/RRESP=00.
- Write 0xAABBCCDD with WSTRB=0101 to reg 1, which holds 0x11223344 -> reads 0x11BB33DD; reg_wr_pulse[1] high exactly one cycle.
- W presented 3 cycles before AW, BREADY held low 5 cycles -> BVALID stays high and stable; second AW not accepted until the B handshake.
- status_in word 0 = 0xCAFE0001; read offset 0x10 (NUM_RW=4) -> 0xCAFE0001 OKAY; write 0x10 -> SLVERR, read unchanged; read 0x24 -> 0, DECERR.
- Same-edge read commit and write commit on reg 2 (old 0x5, new 0x9) -> read returns 0x5, next read returns 0x9.
- ARESETN pulsed low while BVALID=1 -> BVALID=0 next sample; all regs 0; next write completes normally.
- (IRQ build) pulse irq_src[2] -> irq=1, pending reads 0x4; write 0x4 -> irq=0.
